// File: rtl/int_fp_acc_pkg.sv
// Shared types and fp16 constants for the int/fp16 accumulation stage.
package int_fp_pkg;

  typedef enum logic {
    MODE_INT = 1'b0,
    MODE_FP  = 1'b1
  } mode_t;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam int          FP16_BIAS    = 15;

endpackage

// File: rtl/int_fp_acc_if.sv
// Product-beat input stream and group-sum output stream of int_fp_acc.
interface int_fp_acc_if #(
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_mode;
  logic [LEN_W-1:0] out_count;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_count, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_count, out_err
  );
endinterface

// File: rtl/int_fp_acc_fp16_add.sv
// Combinational fp16 adder: RNE, subnormals flushed to signed zero,
// overflow to +/-Inf, canonical quiet NaN for invalid operations.
module fp16_add
  import int_fp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               swap, sx, sub, carry, rnd, found;
  logic [15:0]        x, yv;
  logic [4:0]         ex, ey, d;
  logic [3:0]         dc, lz;
  logic [13:0]        mx, my, al, n;
  logic [27:0]        sh;
  logic [14:0]        sum;
  logic [10:0]        mant_r;
  logic signed [7:0]  e_n, e_r;

  always_comb begin
    a_nan  = (&a[14:10]) && (|a[9:0]);
    b_nan  = (&b[14:10]) && (|b[9:0]);
    a_inf  = (&a[14:10]) && !(|a[9:0]);
    b_inf  = (&b[14:10]) && !(|b[9:0]);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);

    // Order operands by magnitude so the aligned subtraction never goes negative.
    swap = (b[14:0] > a[14:0]);
    x    = swap ? b : a;
    yv   = swap ? a : b;
    sx   = x[15];
    sub  = x[15] ^ yv[15];
    ex   = x[14:10];
    ey   = yv[14:10];
    mx   = {1'b1, x[9:0], 3'b000};
    my   = {1'b1, yv[9:0], 3'b000};
    d    = ex - ey;
    dc   = (d > 5'd15) ? 4'd15 : d[3:0];
    sh   = {my, 14'd0} >> dc;
    al   = {sh[27:15], sh[14] | (|sh[13:0])};
    sum  = sub ? ({1'b0, mx} - {1'b0, al}) : ({1'b0, mx} + {1'b0, al});

    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (!found && sum[13-i]) begin
        lz    = 4'(i);
        found = 1'b1;
      end
    end

    if (sum[14]) begin
      n   = {sum[14:2], sum[1] | sum[0]};
      e_n = $signed({3'b000, ex}) + 8'sd1;
    end else begin
      n   = sum[13:0] << lz;
      e_n = $signed({3'b000, ex}) - $signed({4'b0000, lz});
    end

    rnd             = n[2] && (n[1] || n[0] || n[3]);
    {carry, mant_r} = {2'b01, n[12:3]} + {11'd0, rnd};
    e_r             = e_n + $signed({7'd0, carry});

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      y = FP16_QNAN;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {a[15] & b[15], 15'd0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if (sum == 15'd0) begin
      y = '0;
    end else if (e_r >= $signed(8'(2 * FP16_BIAS + 1))) begin
      y = {sx, FP16_POS_INF[14:0]};
    end else if (e_r <= 8'sd0) begin
      y = {sx, 15'd0};
    end else begin
      y = {sx, e_r[4:0], mant_r[9:0]};
    end
  end

endmodule

// File: rtl/int_fp_acc.sv
// Group accumulator for int16/fp16 product streams, one sum per in_last group.
// Define INT_ACC_SAT_EN for saturating int16 adds (default wraps).
module int_fp_acc
  import int_fp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  int_fp_acc_if.slave  bus
);

  state_t           state;
  logic             first;
  logic             out_valid_q;
  logic             err;
  mode_t            grp_mode;
  logic [15:0]      acc;
  logic [LEN_W-1:0] count;
  logic [15:0]      fp_sum;
  logic [15:0]      int_sum;
`ifdef INT_ACC_SAT_EN
  logic [16:0]      wide;
`endif

  fp16_add u_fp16_add (
    .a (acc),
    .b (bus.in_data),
    .y (fp_sum)
  );

  always_comb begin
`ifdef INT_ACC_SAT_EN
    wide = {acc[15], acc} + {bus.in_data[15], bus.in_data};
    if (wide[16] != wide[15]) begin
      int_sum = wide[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      int_sum = wide[15:0];
    end
`else
    int_sum = acc + bus.in_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACC;
      first       <= 1'b1;
      out_valid_q <= 1'b0;
      err         <= 1'b0;
      grp_mode    <= MODE_INT;
      acc         <= '0;
      count       <= '0;
    end else begin
      case (state)
        ACC: begin
          if (bus.in_valid) begin
            if (first) begin
              acc      <= bus.in_data;
              grp_mode <= mode_t'(bus.in_mode);
              count    <= {{(LEN_W-1){1'b0}}, 1'b1};
              err      <= 1'b0;
              first    <= 1'b0;
            end else begin
              // A mode mismatch is flagged but the beat still uses the group's mode.
              acc <= (grp_mode == MODE_FP) ? fp_sum : int_sum;
              if (count != '1) count <= count + 1'b1;
              if (mode_t'(bus.in_mode) != grp_mode) err <= 1'b1;
            end
            if (bus.in_last) begin
              state       <= DONE;
              first       <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= ACC;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.out_mode  = grp_mode;
  assign bus.out_count = count;
  assign bus.out_err   = err;

endmodule

// File: doc/int_fp_acc.md
# int_fp_acc

Accumulation stage directly downstream of the int/fp16 multiplier `float_multi`. It consumes a stream of 16-bit products, each tagged with the multiplier's mode bit, and sums each group of products delimited by `in_last`. It emits one 16-bit sum per group over a valid/ready handshake. This stage turns the multiplier into a dot-product engine for the accelerator datapath.

## Interface
- `LEN_W`, default 8: width of the beat counter `out_count`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  stage accepts a beat.
- `in_data`  in  16  product; int16 two's complement (mode 0) or IEEE fp16 (mode 1).
- `in_mode`  in  1  0 = int16, 1 = fp16; same encoding as the multiplier `mode`.
- `in_last`  in  1  final beat of the group.
- `out_valid`  out  1  group sum valid.
- `out_ready`  in  1  consumer accepts the sum.
- `out_data`  out  16  group sum.
- `out_mode`  out  1  mode of the group.
- `out_count`  out  LEN_W  beats in the group, saturating at 2^LEN_W-1.
- `out_err`  out  1  mode changed within the group.

## Operation
- States: ACC, DONE. Reset state is ACC.
- Beat acceptance:
  - A beat is accepted when `in_valid && in_ready`.
  - `in_ready = rst_n && (state==ACC)`.
- First beat of a group (`first` flag set):
  - `acc <= in_data`
  - latch `in_mode` into `grp_mode`
  - `count <= 1`
  - `err <= 0`
- Later beats:
  - `acc <= acc ⊕ in_data`, where ⊕ is the `grp_mode` addition.
  - `count` increments and saturates at its maximum.
  - If `in_mode != grp_mode`, set `err`. Still add the beat using `grp_mode`.
- Accepted beat with `in_last=1`:
  - The beat is summed in the same edge.
  - Next state is DONE; `first` is set.
- DONE:
  - `out_valid=1`, and the output registers are held stable.
  - On `out_valid && out_ready`, go to ACC.
- int16 add: 16-bit signed add. Overflow behaviour is set by the macro (see Configuration).
- fp16 add (in `fp16_add`):
  - Round-to-nearest-even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow gives ±Inf.
  - Any NaN operand, or Inf + -Inf, gives 16'h7E00.
  - Exact-zero sum is +0, except (-0)+(-0) = -0.
- Single-beat group (first beat also has `in_last=1`): `out_data = in_data`, `out_count = 1`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 16'h0000, `out_mode` = 0, `out_count` = 0, `out_err` = 0.
  - State is ACC with `first` = 1.
  - `in_ready` is 0 while `rst_n` is low.
- Latency and throughput:
  - `out_valid` rises on the edge that accepts the last beat, so the sum is visible the next cycle.
  - One beat per cycle inside a group.
  - At least one bubble per group, because `in_ready` is 0 during DONE.
- Handshake rules:
  - The outputs stay stable while `out_valid && !out_ready`.
  - `in_valid` is ignored while `in_ready` is 0.
- Reset mid-operation: a partial sum or pending output is discarded, with no output emitted.
- Simultaneous handshakes: a DONE output handshake and a new `in_valid` in the same cycle give no acceptance that cycle. The beat is accepted the next cycle.

## Configuration
- `INT_ACC_SAT_EN`, when defined: int16 adds saturate to 16'h7FFF or 16'h8000.
- Not defined: int16 adds wrap modulo 2^16.
- fp16 behaviour is identical either way.

## Structure
- Package `int_fp_pkg` holds:
  - mode typedef (`MODE_INT=0`, `MODE_FP=1`)
  - state enum
  - constants `FP16_QNAN=16'h7E00`, `FP16_BIAS=15`, `FP16_POS_INF=16'h7C00`
- Sub-module `fp16_add`: purely combinational fp16 adder, instantiated once. The int adder and the control logic stay in `int_fp_acc`.

## Test plan
- fp16 sum:
  - Stimulus: 16'h3C00, 16'h4000, 16'h3800 (`in_last` on the third), mode 1.
  - Required: `out_data=16'h4300` (3.5), `out_count=3`, `out_err=0`.
- int16 sum:
  - Stimulus: 100, 200, -50 (16'hFFCE), mode 0.
  - Required: `out_data=16'h00FA`.
- int16 overflow:
  - Stimulus: 16'h7000 + 16'h7000.
  - Required: 16'h7FFF with `INT_ACC_SAT_EN`; 16'hE000 without it.
- fp16 special values:
  - 16'h7C00 + 16'hFC00 → 16'h7E00.
  - 16'h7BFF + 16'h7BFF → 16'h7C00.
- Backpressure:
  - Stimulus: hold `out_ready=0` for 5 cycles after a sum.
  - Required: `out_data` stable, `in_ready=0`. Release → a handshake in one cycle, and the next group starts fresh.
- Mode mismatch, then mid-group reset:
  - Mismatch stimulus: beats mode 1,0,1.
  - Mismatch required: `out_err=1`, sum computed as fp16.
  - Reset stimulus: `rst_n` low after 2 beats of a group.
  - Reset required: no output; the next group starting with 16'h4200 alone gives 16'h4200.
